// File: rtl/inst_cache.sv
// Direct-mapped instruction cache beside IF: one-cycle registered lookup, same-edge fill forwarding, flush.
// Optional hit/miss counters are built when INST_CACHE_STATS_EN is defined; otherwise both outputs are 0.
module inst_cache #(
   parameter int ENTRIES = 256,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cache_query,
   input  logic [ADDR_W-1:0] query_addr,
   output logic              inst_hit,
   output logic [31:0]       cache_inst_o,
   input  logic              cache_enable,
   input  logic [ADDR_W-1:0] inst_cache_addr_i,
   input  logic [31:0]       inst_cache_i,
   input  logic              flush_i,
   output logic [31:0]       stat_hits_o,
   output logic [31:0]       stat_miss_o
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;

   // Handshake: cache_query is sampled every rising edge with no ready; inst_hit and
   // cache_inst_o answer it after that edge. Fills are fire-and-forget, one per edge.
   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tag_mem  [ENTRIES];
   logic [31:0]        data_mem [ENTRIES];

   logic [IDX_W-1:0] q_idx, f_idx;
   logic [TAG_W-1:0] q_tag, f_tag;
   logic             fwd, arr_hit, hit_now;
   logic [31:0]      hit_data;
   logic             unused_low_bits;

   assign q_idx = query_addr[IDX_W+1:2];
   assign q_tag = query_addr[ADDR_W-1:IDX_W+2];
   assign f_idx = inst_cache_addr_i[IDX_W+1:2];
   assign f_tag = inst_cache_addr_i[ADDR_W-1:IDX_W+2];
   assign unused_low_bits = ^{query_addr[1:0], inst_cache_addr_i[1:0]};

   // A same-line fill forwards its data; a different tag at the same index sees the old line.
   assign fwd      = cache_enable && (f_idx == q_idx) && (f_tag == q_tag);
   assign arr_hit  = valid[q_idx] && (tag_mem[q_idx] == q_tag);
   assign hit_now  = cache_query && !flush_i && (fwd || arr_hit);
   assign hit_data = fwd ? inst_cache_i : data_mem[q_idx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid        <= '0;
         inst_hit     <= 1'b0;
         cache_inst_o <= 32'd0;
      end else begin
         if (flush_i)
            valid <= '0;
         else if (cache_enable)
            valid[f_idx] <= 1'b1;

         if (cache_query) begin
            inst_hit     <= hit_now;
            cache_inst_o <= hit_now ? hit_data : 32'd0;
         end else begin
            inst_hit <= 1'b0;
         end
      end
   end

   // Tag and data arrays carry no reset; valid bits alone qualify their contents.
   always_ff @(posedge clk) begin
      if (cache_enable && !flush_i) begin
         tag_mem[f_idx]  <= f_tag;
         data_mem[f_idx] <= inst_cache_i;
      end
   end

`ifdef INST_CACHE_STATS_EN
   logic [31:0] hits_q, miss_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hits_q <= 32'd0;
         miss_q <= 32'd0;
      end else if (cache_query) begin
         if (hit_now)
            hits_q <= hits_q + 32'd1;
         else
            miss_q <= miss_q + 32'd1;
      end
   end

   assign stat_hits_o = hits_q;
   assign stat_miss_o = miss_q;
`else
   assign stat_hits_o = 32'd0;
   assign stat_miss_o = 32'd0;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: lookup, aliasing, forwarding, flush, async reset, pipelining, counters.
module tb_inst_cache;
   logic        clk;
   logic        rst;
   logic        cache_query;
   logic [31:0] query_addr;
   logic        inst_hit;
   logic [31:0] cache_inst_o;
   logic        cache_enable;
   logic [31:0] inst_cache_addr_i;
   logic [31:0] inst_cache_i;
   logic        flush_i;
   logic [31:0] stat_hits_o;
   logic [31:0] stat_miss_o;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [31:0] exp_q[$];
   logic        exp_hit_q[$];

   inst_cache #(.ENTRIES(256), .ADDR_W(32)) dut (
      .clk               (clk),
      .rst               (rst),
      .cache_query       (cache_query),
      .query_addr        (query_addr),
      .inst_hit          (inst_hit),
      .cache_inst_o      (cache_inst_o),
      .cache_enable      (cache_enable),
      .inst_cache_addr_i (inst_cache_addr_i),
      .inst_cache_i      (inst_cache_i),
      .flush_i           (flush_i),
      .stat_hits_o       (stat_hits_o),
      .stat_miss_o       (stat_miss_o)
   );

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are read on the falling edge after the sampling edge.
   task automatic idle_inputs();
      cache_query = 1'b0; query_addr = 32'd0;
      cache_enable = 1'b0; inst_cache_addr_i = 32'd0; inst_cache_i = 32'd0;
      flush_i = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic drive_fill(input logic [31:0] a, input logic [31:0] d);
      idle_inputs();
      cache_enable = 1'b1; inst_cache_addr_i = a; inst_cache_i = d;
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic drive_query(input logic [31:0] a);
      idle_inputs();
      cache_query = 1'b1; query_addr = a;
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (inst_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %0b want 0", inst_hit); end
      n_cmp++; if (cache_inst_o !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", cache_inst_o); end
      n_cmp++; if (stat_hits_o !== 32'd0) begin n_fail++; $display("FAIL reset_stat_hits got %0d want 0", stat_hits_o); end
      n_cmp++; if (stat_miss_o !== 32'd0) begin n_fail++; $display("FAIL reset_stat_miss got %0d want 0", stat_miss_o); end
      drive_query(32'h0000_0000);
      n_cmp++; if (inst_hit !== 1'b0) begin n_fail++; $display("FAIL cold_query_hit got %0b want 0", inst_hit); end
      n_cmp++; if (cache_inst_o !== 32'd0) begin n_fail++; $display("FAIL cold_query_data got %h want 0", cache_inst_o); end
   endtask

   task automatic test_fill_hit();
      drive_fill(32'h0000_0004, 32'h0000_0013);
      drive_query(32'h0000_0004);
      n_cmp++; if (inst_hit !== 1'b1) begin n_fail++; $display("FAIL fill_hit got %0b want 1", inst_hit); end
      n_cmp++; if (cache_inst_o !== 32'h0000_0013) begin n_fail++; $display("FAIL fill_data got %h want 00000013", cache_inst_o); end
      drive_query(32'h0000_0006);
      n_cmp++; if (inst_hit !== 1'b1) begin n_fail++; $display("FAIL lowbits_hit got %0b want 1", inst_hit); end
      n_cmp++; if (cache_inst_o !== 32'h0000_0013) begin n_fail++; $display("FAIL lowbits_data got %h want 00000013", cache_inst_o); end
   endtask

   task automatic test_hold();
      // Previous cycle hit with 0x13; an idle edge drops inst_hit but keeps the data.
      @(negedge clk);
      n_cmp++; if (inst_hit !== 1'b0) begin n_fail++; $display("FAIL hold_hit got %0b want 0", inst_hit); end
      n_cmp++; if (cache_inst_o !== 32'h0000_0013) begin n_fail++; $display("FAIL hold_data got %h want 00000013", cache_inst_o); end
   endtask

   task automatic test_alias();
      drive_fill(32'h0000_0008, 32'hAAAA_AAAA);
      drive_fill(32'h0000_0408, 32'h5555_5555);
      drive_query(32'h0000_0408);
      n_cmp++; if (inst_hit !== 1'b1) begin n_fail++; $display("FAIL alias_new_hit got %0b want 1", inst_hit); end
      n_cmp++; if (cache_inst_o !== 32'h5555_5555) begin n_fail++; $display("FAIL alias_new_data got %h want 55555555", cache_inst_o); end
      drive_query(32'h0000_0008);
      n_cmp++; if (inst_hit !== 1'b0) begin n_fail++; $display("FAIL alias_old_hit got %0b want 0", inst_hit); end
      n_cmp++; if (cache_inst_o !== 32'd0) begin n_fail++; $display("FAIL alias_old_data got %h want 0", cache_inst_o); end
   endtask

   task automatic test_forward();
      idle_inputs();
      cache_query = 1'b1; query_addr = 32'h0000_0010;
      cache_enable = 1'b1; inst_cache_addr_i = 32'h0000_0010; inst_cache_i = 32'h0010_0093;
      @(negedge clk);
      idle_inputs();
      n_cmp++; if (inst_hit !== 1'b1) begin n_fail++; $display("FAIL fwd_hit got %0b want 1", inst_hit); end
      n_cmp++; if (cache_inst_o !== 32'h0010_0093) begin n_fail++; $display("FAIL fwd_data got %h want 00100093", cache_inst_o); end
      // Same index, different tag: lookup sees the old line, then the fill evicts it.
      cache_query = 1'b1; query_addr = 32'h0000_0010;
      cache_enable = 1'b1; inst_cache_addr_i = 32'h0000_0410; inst_cache_i = 32'h1234_5678;
      @(negedge clk);
      idle_inputs();
      n_cmp++; if (inst_hit !== 1'b1) begin n_fail++; $display("FAIL conflict_hit got %0b want 1", inst_hit); end
      n_cmp++; if (cache_inst_o !== 32'h0010_0093) begin n_fail++; $display("FAIL conflict_data got %h want 00100093", cache_inst_o); end
      drive_query(32'h0000_0010);
      n_cmp++; if (inst_hit !== 1'b0) begin n_fail++; $display("FAIL evicted_hit got %0b want 0", inst_hit); end
      drive_query(32'h0000_0410);
      n_cmp++; if (cache_inst_o !== 32'h1234_5678) begin n_fail++; $display("FAIL evictor_data got %h want 12345678", cache_inst_o); end
   endtask

   task automatic test_flush();
      logic [31:0] addrs [4];
      addrs[0] = 32'h0000_0004; addrs[1] = 32'h0000_0408;
      addrs[2] = 32'h0000_0410; addrs[3] = 32'h0000_0020;
      drive_fill(32'h0000_0030, 32'h0000_3030);
      // Flush with a concurrent fill to 0x20 and a concurrent query to a resident line.
      idle_inputs();
      flush_i = 1'b1;
      cache_enable = 1'b1; inst_cache_addr_i = 32'h0000_0020; inst_cache_i = 32'h0000_2020;
      cache_query = 1'b1; query_addr = 32'h0000_0030;
      @(negedge clk);
      idle_inputs();
      n_cmp++; if (inst_hit !== 1'b0) begin n_fail++; $display("FAIL flush_same_edge_hit got %0b want 0", inst_hit); end
      n_cmp++; if (cache_inst_o !== 32'd0) begin n_fail++; $display("FAIL flush_same_edge_data got %h want 0", cache_inst_o); end
      for (int i = 0; i < 4; i++) begin
         drive_query(addrs[i]);
         n_cmp++; if (inst_hit !== 1'b0) begin n_fail++; $display("FAIL flush_miss addr=%h got %0b want 0", addrs[i], inst_hit); end
      end
   endtask

   task automatic test_async_reset();
      drive_fill(32'h0000_0040, 32'h0000_DEAD);
      drive_query(32'h0000_0040);
      n_cmp++; if (inst_hit !== 1'b1) begin n_fail++; $display("FAIL pre_reset_hit got %0b want 1", inst_hit); end
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (inst_hit !== 1'b0) begin n_fail++; $display("FAIL async_reset_hit got %0b want 0", inst_hit); end
      n_cmp++; if (cache_inst_o !== 32'd0) begin n_fail++; $display("FAIL async_reset_data got %h want 0", cache_inst_o); end
      @(negedge clk);
      rst = 1'b1;
      drive_query(32'h0000_0040);
      n_cmp++; if (inst_hit !== 1'b0) begin n_fail++; $display("FAIL post_reset_miss got %0b want 0", inst_hit); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d, e;
      logic        h;
      for (int i = 0; i < 4; i++) drive_fill(32'h0000_0050 + 32'(i * 4), 32'hC0DE_0000 + 32'(i));
      idle_inputs();
      for (int i = 0; i < 6; i++) begin
         if (i < 5) begin
            cache_query = 1'b1; query_addr = 32'h0000_0050 + 32'(i * 4);
            if (i < 4) begin d = 32'hC0DE_0000 + 32'(i); h = 1'b1; end
            else       begin d = 32'd0; h = 1'b0; end
            exp_q.push_back(d); exp_hit_q.push_back(h);
         end else begin
            cache_query = 1'b0;
         end
         @(negedge clk);
         e = exp_q.pop_front(); h = exp_hit_q.pop_front();
         n_cmp++; if (inst_hit !== h || cache_inst_o !== e) begin
            n_fail++; $display("FAIL b2b[%0d] got hit=%0b data=%h want hit=%0b data=%h", i, inst_hit, cache_inst_o, h, e);
         end
         if (i == 4) break;
      end
      idle_inputs();
   endtask

   task automatic test_stats();
      do_reset();
      drive_fill(32'h0000_0080, 32'h0000_8080);
      for (int i = 0; i < 3; i++) drive_query(32'h0000_0080);
      drive_query(32'h0000_0084);
      drive_query(32'h0000_0088);
`ifdef INST_CACHE_STATS_EN
      n_cmp++; if (stat_hits_o !== 32'd3) begin n_fail++; $display("FAIL stat_hits got %0d want 3", stat_hits_o); end
      n_cmp++; if (stat_miss_o !== 32'd2) begin n_fail++; $display("FAIL stat_miss got %0d want 2", stat_miss_o); end
`else
      n_cmp++; if (stat_hits_o !== 32'd0) begin n_fail++; $display("FAIL stat_hits got %0d want 0", stat_hits_o); end
      n_cmp++; if (stat_miss_o !== 32'd0) begin n_fail++; $display("FAIL stat_miss got %0d want 0", stat_miss_o); end
`endif
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      test_reset();
      test_fill_hit();
      test_hold();
      test_alias();
      test_forward();
      test_flush();
      test_async_reset();
      test_back_to_back();
      test_stats();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
